load_store_unit: RTL

- Initiator side of the datapath's data-memory interface.
- Accepts one load/store request from the multi-cycle control FSM and computes the effective address.
- Drives word-addressed read/write strobes into the 32-word data memory. That memory has a registered read with 1-cycle latency and a synchronous write.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads, then returns a done/err pulse.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus between the load/store unit (master) and
// the 32-word data memory (slave). Read data returns one cycle after mem_read.
interface load_store_unit_if #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: computes the effective address of one request, runs the
// memory read / read-modify-write / write sequence and returns done/err.
module load_store_unit #(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] base,
  input  logic [11:0]     imm,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] load_data,
  load_store_unit_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] eff;
  logic            legal;
  logic            misaligned;
  logic            op_store;
  logic [2:0]      op_funct3;
  logic [1:0]      op_lane;
  logic [15:0]     op_data;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ext_load;
  logic [XLEN-1:0] merged;
  logic            unused_eff_bits;

  // Only the word index and byte lane of the effective address matter;
  // the upper bits wrap modulo the memory depth.
  assign eff             = base + {{(XLEN-12){imm[11]}}, imm};
  assign unused_eff_bits = ^eff[XLEN-1:ADDR_W+2];

  // Strobes and status come straight from the registered state.
  assign mem.mem_read  = (state == RD);
  assign mem.mem_write = (state == WR);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE) || (state == ERR);
  assign err           = (state == ERR);

  // Classify the incoming request as legal and aligned or not.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    if ((funct3[1:0] == 2'b01) && eff[0]) begin
      misaligned = 1'b1;
    end
    if ((funct3[1:0] == 2'b10) && (eff[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: full-word stores skip the read, sub-word stores merge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!legal || misaligned) begin
            state_next = ERR;
          end else if (is_store && (funct3 == 3'b010)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = RDW;
      RDW:     state_next = op_store ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pick the addressed lane of the returned word and build both the
  // extended load result and the merged sub-word store word.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = op_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    ext_load = mem.mem_rdata;
    merged   = mem.mem_rdata;
    case (op_lane)
      2'd0:    rd_byte = mem.mem_rdata[7:0];
      2'd1:    rd_byte = mem.mem_rdata[15:8];
      2'd2:    rd_byte = mem.mem_rdata[23:16];
      default: rd_byte = mem.mem_rdata[31:24];
    endcase
    case (op_funct3)
      3'b000:  ext_load = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      3'b001:  ext_load = {{(XLEN-16){rd_half[15]}}, rd_half};
      3'b100:  ext_load = {{(XLEN-8){1'b0}}, rd_byte};
      3'b101:  ext_load = {{(XLEN-16){1'b0}}, rd_half};
      default: ext_load = mem.mem_rdata;
    endcase
    if (op_funct3[1:0] == 2'b00) begin
      case (op_lane)
        2'd0:    merged[7:0]   = op_data[7:0];
        2'd1:    merged[15:8]  = op_data[7:0];
        2'd2:    merged[23:16] = op_data[7:0];
        default: merged[31:24] = op_data[7:0];
      endcase
    end else if (op_funct3[1:0] == 2'b01) begin
      if (op_lane[1]) begin
        merged[31:16] = op_data;
      end else begin
        merged[15:0] = op_data;
      end
    end
  end

  // Latch the request on acceptance, then capture read data in RDW;
  // later requests while busy never touch these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store      <= 1'b0;
      op_funct3     <= 3'b000;
      op_lane       <= 2'b00;
      op_data       <= 16'h0000;
      load_data     <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      if ((state == IDLE) && req) begin
        op_store     <= is_store;
        op_funct3    <= funct3;
        op_lane      <= eff[1:0];
        op_data      <= store_data[15:0];
        mem.mem_addr <= eff[ADDR_W+1:2];
        if (state_next == WR) begin
          mem.mem_wdata <= store_data;
        end
      end
      if (state == RDW) begin
        if (op_store) begin
          mem.mem_wdata <= merged;
        end else begin
          load_data <= ext_load;
        end
      end
    end
  end

endmodule
